// File: rtl/coherency_pkg.sv
// Shared geometry, snoop encodings, FSM states and tag-word helper for the
// 8-line, 16-byte-line cache coherency logic.
package coherency_pkg;

  localparam int unsigned ADDR_BITS     = 32;
  localparam int unsigned INDEX_BITS    = 3;
  localparam int unsigned OFFSET_BITS   = 4;
  localparam int unsigned TAG_VALID_BIT = 31;
  localparam int unsigned TAG_BITS      = 32;
  localparam int unsigned NUM_LINES     = 1 << INDEX_BITS;
  localparam int unsigned HIT_CNT_BITS  = 16;

  localparam logic SNP_BUSRD  = 1'b0;
  localparam logic SNP_BUSRDX = 1'b1;

  typedef logic [ADDR_BITS-1:0]  addr_t;
  typedef logic [INDEX_BITS-1:0] idx_t;
  typedef logic [TAG_BITS-1:0]   tag_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    INVAL  = 2'd2,
    RESP   = 2'd3
  } snp_state_e;

  // Snoop request as captured from the bus
  typedef struct packed {
    logic  rdx;
    addr_t addr;
  } snp_req_t;

  // Valid bit set, line address in the low bits, pad bits zero
  function automatic tag_t tag_word(input addr_t addr);
    tag_t w;
    w = TAG_BITS'(addr[ADDR_BITS-1:OFFSET_BITS]);
    w[TAG_VALID_BIT] = 1'b1;
    return w;
  endfunction

  function automatic idx_t line_idx(input addr_t addr);
    return addr[OFFSET_BITS +: INDEX_BITS];
  endfunction

endpackage

// File: rtl/snoop_responder_if.sv
// Snoop channel, snoop tag-port and invalidation channel bundle.
// slave = the responder, master = bus/array/controller side.
interface snoop_responder_if;
  import coherency_pkg::*;

  logic                 snp_req_val;
  logic                 snp_req_rdy;
  logic                 snp_req_type;
  addr_t                snp_req_addr;

  logic                 snp_resp_val;
  logic                 snp_resp_rdy;
  logic                 snp_resp_hit;
  logic                 snp_resp_dirty;

  logic                 tag_read_en2;
  idx_t                 addr2;
  tag_t                 tag_tag;
  logic                 tag_match2;
  logic [NUM_LINES-1:0] line_dirty;

  logic                 inv_req_val;
  logic                 inv_req_rdy;
  idx_t                 inv_req_idx;

  modport slave (
    input  snp_req_val, snp_req_type, snp_req_addr, snp_resp_rdy,
           tag_match2, line_dirty, inv_req_rdy,
    output snp_req_rdy, snp_resp_val, snp_resp_hit, snp_resp_dirty,
           tag_read_en2, addr2, tag_tag, inv_req_val, inv_req_idx
  );

  modport master (
    output snp_req_val, snp_req_type, snp_req_addr, snp_resp_rdy,
           tag_match2, line_dirty, inv_req_rdy,
    input  snp_req_rdy, snp_resp_val, snp_resp_hit, snp_resp_dirty,
           tag_read_en2, addr2, tag_tag, inv_req_val, inv_req_idx
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/snoop_responder.sv
// Bus-side snoop responder: probes the snoop tag port, invalidates locally on
// BusRdX hits, then returns hit/dirty status to the bus.
module snoop_responder
  import coherency_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  snoop_responder_if.slave        bus,
  output logic [HIT_CNT_BITS-1:0] hit_count
);

  snp_state_e state;
  snp_state_e state_n;

  snp_req_t   req_q;
  logic       hit_q;
  logic       dirty_q;

  logic       req_rdy_q;
  logic       resp_val_q;
  logic       inv_val_q;
  logic       rd_en_q;

  logic       accept_c;
  logic       lookup_hit_c;
  idx_t       idx_c;
  logic       offset_unused;

  assign idx_c         = line_idx(req_q.addr);
  assign accept_c      = req_rdy_q & bus.snp_req_val;
  assign lookup_hit_c  = (state == LOOKUP) & bus.tag_match2;
  assign offset_unused = ^req_q.addr[OFFSET_BITS-1:0];

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept_c) state_n = LOOKUP;
      LOOKUP:  state_n = ((req_q.rdx == SNP_BUSRDX) && bus.tag_match2) ? INVAL : RESP;
      INVAL:   if (bus.inv_req_rdy) state_n = RESP;
      RESP:    if (bus.snp_resp_rdy) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register; handshake outputs are decoded from the next state so they
  // come straight off flops and drop asynchronously on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req_rdy_q  <= 1'b1;
      resp_val_q <= 1'b0;
      inv_val_q  <= 1'b0;
      rd_en_q    <= 1'b0;
    end else begin
      state      <= state_n;
      req_rdy_q  <= (state_n == IDLE);
      resp_val_q <= (state_n == RESP);
      inv_val_q  <= (state_n == INVAL);
      rd_en_q    <= (state_n == LOOKUP);
    end
  end

  // Request capture and lookup result; line_dirty is only sampled in LOOKUP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q   <= '{rdx: SNP_BUSRD, addr: '0};
      hit_q   <= 1'b0;
      dirty_q <= 1'b0;
    end else begin
      if (accept_c) begin
        req_q <= '{rdx: bus.snp_req_type, addr: bus.snp_req_addr};
      end
      if (state == LOOKUP) begin
        hit_q   <= bus.tag_match2;
        dirty_q <= bus.tag_match2 & bus.line_dirty[idx_c];
      end
    end
  end

  sat_counter #(
    .WIDTH (HIT_CNT_BITS)
  ) u_hit_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (lookup_hit_c),
    .count (hit_count)
  );

  assign bus.snp_req_rdy    = req_rdy_q;
  assign bus.snp_resp_val   = resp_val_q;
  assign bus.snp_resp_hit   = hit_q;
  assign bus.snp_resp_dirty = dirty_q;
  assign bus.tag_read_en2   = rd_en_q;
  assign bus.addr2          = idx_c;
  assign bus.tag_tag        = tag_word(req_q.addr);
  assign bus.inv_req_val    = inv_val_q;
  assign bus.inv_req_idx    = idx_c;

endmodule

// File: tb/tb_snoop_responder.sv
// Scoreboarded bench for snoop_responder with a behavioural tag array and
// invalidation controller.
module tb_snoop_responder;
  import coherency_pkg::*;

  typedef struct packed {
    logic hit;
    logic dirty;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [HIT_CNT_BITS-1:0] hit_count;

  logic       sat_rst;
  logic       sat_inc;
  logic [2:0] sat_cnt;

  logic [31:0] tag_mem [NUM_LINES];
  exp_t        sb [$];
  exp_t        mon_e;
  int          n_cmp   = 0;
  int          n_err   = 0;
  int          exp_hits = 0;

  snoop_responder_if sif ();

  snoop_responder dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (sif.slave),
    .hit_count (hit_count)
  );

  sat_counter #(.WIDTH(3)) u_sat (
    .clk   (clk),
    .reset (sat_rst),
    .inc   (sat_inc),
    .count (sat_cnt)
  );

  always #5 clk = ~clk;

  // Tag array snoop port: combinational compare against the stored word
  always_comb sif.tag_match2 = sif.tag_read_en2 && (tag_mem[sif.addr2] == sif.tag_tag);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Response monitor: pop the oldest expectation on each response handshake
  always @(negedge clk) begin
    if (!reset && sif.snp_resp_val && sif.snp_resp_rdy) begin
      if (sb.size() == 0) begin
        check("resp_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("resp_hit", 32'(sif.snp_resp_hit), 32'(mon_e.hit));
        check("resp_dirty", 32'(sif.snp_resp_dirty), 32'(mon_e.dirty));
      end
    end
  end

  function automatic logic [31:0] model_tag(input logic [31:0] a);
    return {1'b1, 3'b000, a[31:4]};
  endfunction

  task automatic snoop(input logic rdx, input logic [31:0] addr, input int inv_hold,
                       input int resp_hold, input bit flip_dirty);
    logic [2:0] idx;
    logic ehit, edirty, einv, h0, d0;
    int waits, inv_cyc, resp_cyc, first_inv, first_resp;
    bit done;
    idx = addr[6:4];
    ehit   = (tag_mem[idx] == model_tag(addr));
    edirty = ehit & sif.line_dirty[idx];
    einv   = rdx & ehit;
    sb.push_back('{hit: ehit, dirty: edirty});
    if (ehit && exp_hits < 65535) exp_hits++;
    inv_cyc = 0; resp_cyc = 0; first_inv = -1; first_resp = -1; done = 0;
    h0 = 1'b0; d0 = 1'b0;

    sif.snp_req_type = rdx;
    sif.snp_req_addr = addr;
    sif.snp_req_val  = 1'b1;
    waits = 0;
    while (!sif.snp_req_rdy && waits < 20) begin
      @(posedge clk); #1;
      waits++;
    end
    check("accept_wait", 32'(waits), 32'd0);
    @(posedge clk); #1;
    sif.snp_req_val  = 1'b0;
    sif.snp_req_addr = $urandom;
    check("lookup_rd_en", 32'(sif.tag_read_en2), 32'd1);
    check("lookup_addr2", 32'(sif.addr2), 32'(idx));
    check("lookup_tag", sif.tag_tag, model_tag(addr));
    check("lookup_no_resp", 32'(sif.snp_resp_val), 32'd0);
    @(posedge clk); #1;

    for (int cyc = 2; cyc < 40 && !done; cyc++) begin
      if (flip_dirty && cyc == 2) sif.line_dirty = ~sif.line_dirty;
      check("busy_req_rdy", 32'(sif.snp_req_rdy), 32'd0);
      sif.inv_req_rdy  = 1'b0;
      sif.snp_resp_rdy = 1'b0;
      if (sif.inv_req_val) begin
        if (first_inv < 0) first_inv = cyc;
        inv_cyc++;
        check("inv_idx", 32'(sif.inv_req_idx), 32'(idx));
        if (inv_cyc > inv_hold) begin
          sif.inv_req_rdy = 1'b1;
          tag_mem[idx] = '0;
        end
      end
      if (sif.snp_resp_val) begin
        if (first_resp < 0) begin
          first_resp = cyc;
          h0 = sif.snp_resp_hit;
          d0 = sif.snp_resp_dirty;
        end else begin
          check("hold_hit", 32'(sif.snp_resp_hit), 32'(h0));
          check("hold_dirty", 32'(sif.snp_resp_dirty), 32'(d0));
        end
        resp_cyc++;
        if (resp_cyc > resp_hold) begin
          sif.snp_resp_rdy = 1'b1;
          done = 1;
        end
      end
      @(posedge clk); #1;
    end
    sif.inv_req_rdy  = 1'b0;
    sif.snp_resp_rdy = 1'b0;
    check("resp_timeout", 32'(done), 32'd1);
    check("first_inv_cycle", 32'(first_inv), einv ? 32'd2 : 32'hFFFF_FFFF);
    check("inv_cycles", 32'(inv_cyc), einv ? 32'(inv_hold + 1) : 32'd0);
    check("first_resp_cycle", 32'(first_resp), einv ? 32'(inv_hold + 3) : 32'd2);
    check("post_req_rdy", 32'(sif.snp_req_rdy), 32'd1);
    check("post_resp_val", 32'(sif.snp_resp_val), 32'd0);
    check("hit_count", 32'(hit_count), 32'(exp_hits));
  endtask

  initial begin
    logic [31:0] a;
    int          waits;
    reset            = 1'b1;
    sat_rst          = 1'b1;
    sat_inc          = 1'b0;
    sif.snp_req_val  = 1'b0;
    sif.snp_req_type = SNP_BUSRD;
    sif.snp_req_addr = '0;
    sif.snp_resp_rdy = 1'b0;
    sif.inv_req_rdy  = 1'b0;
    sif.line_dirty   = '0;
    foreach (tag_mem[i]) tag_mem[i] = '0;

    #1;
    check("rst_req_rdy", 32'(sif.snp_req_rdy), 32'd1);
    check("rst_resp_val", 32'(sif.snp_resp_val), 32'd0);
    check("rst_inv_val", 32'(sif.inv_req_val), 32'd0);
    check("rst_rd_en", 32'(sif.tag_read_en2), 32'd0);
    check("rst_hit", 32'(sif.snp_resp_hit), 32'd0);
    check("rst_dirty", 32'(sif.snp_resp_dirty), 32'd0);
    check("rst_hit_count", 32'(hit_count), 32'd0);
    check("rst_tag_tag", sif.tag_tag, 32'h8000_0000);
    check("rst_addr2", 32'(sif.addr2), 32'd0);
    @(negedge clk);
    reset   = 1'b0;
    sat_rst = 1'b0;
    @(posedge clk); #1;

    // Miss on an invalid line
    snoop(SNP_BUSRD, 32'h0000_0020, 0, 0, 0);
    // Clean BusRd hit on line 5
    tag_mem[5] = 32'h8123_4565;
    snoop(SNP_BUSRD, 32'h1234_5650, 0, 0, 0);
    // BusRdX dirty hit, controller slow by 3 cycles
    sif.line_dirty = 8'h20;
    snoop(SNP_BUSRDX, 32'h1234_5650, 3, 0, 0);
    // Line is gone after the invalidation
    snoop(SNP_BUSRDX, 32'h1234_5650, 0, 0, 0);
    // Backpressure with line_dirty flipping after lookup, then back-to-back
    tag_mem[5] = 32'h8123_4565;
    sif.line_dirty = 8'h20;
    snoop(SNP_BUSRD, 32'h1234_5650, 0, 5, 1);
    snoop(SNP_BUSRD, 32'h1234_5650, 0, 0, 0);
    // Same index, different tag
    snoop(SNP_BUSRD, 32'h4234_5650, 0, 0, 0);
    // BusRdX clean hit with controller ready immediately
    tag_mem[2] = model_tag(32'hABCD_0020);
    sif.line_dirty = 8'h00;
    snoop(SNP_BUSRDX, 32'hABCD_002C, 0, 1, 0);

    // Random mix over a small address set
    for (int i = 0; i < NUM_LINES; i++) begin
      a = {23'h0, 1'($urandom_range(0, 1)), 1'b0, 3'(i), 4'h0};
      tag_mem[i] = ($urandom_range(0, 3) != 0) ? model_tag(a) : 32'h0;
    end
    sif.line_dirty = 8'($urandom);
    for (int i = 0; i < 12; i++) begin
      a = {23'h0, 1'($urandom_range(0, 1)), 1'b0, 3'($urandom_range(0, 7)), 4'($urandom)};
      snoop(1'($urandom_range(0, 1)), a, $urandom_range(0, 2), $urandom_range(0, 2), 0);
    end

    // Reset while an invalidation is pending
    tag_mem[3] = model_tag(32'h0000_0030);
    sif.line_dirty = 8'h08;
    sif.snp_req_type = SNP_BUSRDX;
    sif.snp_req_addr = 32'h0000_0030;
    sif.snp_req_val  = 1'b1;
    @(posedge clk); #1;
    sif.snp_req_val = 1'b0;
    waits = 0;
    while (!sif.inv_req_val && waits < 5) begin
      @(posedge clk); #1;
      waits++;
    end
    check("rst_mid_inv_seen", 32'(sif.inv_req_val), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_inv_drop", 32'(sif.inv_req_val), 32'd0);
    check("rst_mid_req_rdy", 32'(sif.snp_req_rdy), 32'd1);
    check("rst_mid_resp_val", 32'(sif.snp_resp_val), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_hits = 0;
    @(posedge clk); #1;
    check("rst_mid_hit_count", 32'(hit_count), 32'd0);
    check("rst_mid_idle_rdy", 32'(sif.snp_req_rdy), 32'd1);
    check("rst_mid_no_inv", 32'(sif.inv_req_val), 32'd0);
    check("rst_mid_no_resp", 32'(sif.snp_resp_val), 32'd0);
    snoop(SNP_BUSRD, 32'h0000_0030, 0, 0, 0);

    // Saturating counter sticks at all-ones
    for (int i = 1; i <= 10; i++) begin
      sat_inc = 1'b1;
      @(posedge clk); #1;
      check("sat_count", 32'(sat_cnt), (i > 7) ? 32'd7 : 32'(i));
    end
    sat_inc = 1'b0;
    @(posedge clk); #1;
    check("sat_hold", 32'(sat_cnt), 32'd7);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
